miriscv_mem_arbiter: RTL and testbench
======================================

// Module: miriscv_mem_arbiter
// PURPOSE
// - Sits downstream of the miriscv core and merges its instruction and data memory ports onto one shared memory port.
// - Buffers one request per core port and arbitrates between them, data first.
// - Tracks outstanding requests and routes in-order memory responses back to the issuing core port.
// PARAMETERS
// - XLEN             32  data/address width
// - MAX_OUTSTANDING  2   shared-port requests in flight; power of 2, >=1
// PORTS
// - clk_i           in   1        clock
// - arstn_i         in   1        async reset, active low
// - instr_req_i     in   1        core instr request, 1-cycle pulse
// - instr_addr_i    in   XLEN     core instr address
// - instr_rvalid_o  out  1        instr response valid
// - instr_rdata_o   out  XLEN     instr response data
// - data_req_i      in   1        core data request, 1-cycle pulse
// - data_we_i       in   1        write enable
// - data_be_i       in   XLEN/8   byte enables
// - data_addr_i     in   XLEN     data address
// - data_wdata_i    in   XLEN     write data
// - data_rvalid_o   out  1        data response valid (reads and writes)
// - data_rdata_o    out  XLEN     data response data
// - mem_req_o       out  1        shared request valid
// - mem_gnt_i       in   1        memory accepts request this cycle
// - mem_we_o        out  1        shared write enable
// - mem_be_o        out  XLEN/8   shared byte enables
// - mem_addr_o      out  XLEN     shared address
// - mem_wdata_o     out  XLEN     shared write data
// - mem_rvalid_i    in   1        memory response valid, in grant order, one per grant
// - mem_rdata_i     in   XLEN     memory response data
// - err_o           out  1        sticky protocol error
// BEHAVIOUR
// - Single clock clk_i; reset arstn_i asynchronous, active low.
// - Reset state: all pending buffers empty, ID FIFO empty, err_o=0. All outputs are 0.
// - Each core port has a 1-entry pending register. A *_req_i pulse loads it at the next edge.
// - Core contract: at most one outstanding request per port. A port waits for its rvalid before issuing again.
// - A *_req_i while that port's pending register is full is a protocol violation. It sets err_o and the request is dropped.
// - Issue: mem_req_o=1 when any pending register is valid and the ID FIFO is not full.
//   - Data pending wins over instr pending.
//   - mem_* fields come from the winner, selected combinationally.
//   - For instr requests mem_we_o=0, mem_be_o='1, mem_wdata_o=0.
// - Handshake: on mem_req_o && mem_gnt_i, the winner's pending register clears and its source ID is pushed into the FIFO.
// - Without a grant, mem_req_o and the selected fields hold stable. Arbitration may not switch away from a presented request until it is granted.
// - Latency: core req at edge N, earliest mem_req_o in cycle N+1. The response on mem_rvalid_i is forwarded in the same cycle (combinational).
// - Response: on mem_rvalid_i the FIFO head ID selects the port.
//   - The selected *_rvalid_o=1 and *_rdata_o=mem_rdata_i; the other port's outputs are 0.
//   - The FIFO pops.
// - mem_rvalid_i with the FIFO empty is dropped and sets err_o.
// - Simultaneous grant and rvalid: push and pop in the same cycle; occupancy is unchanged.
// - Full FIFO with a simultaneous pop: the push is not allowed that cycle (mem_req_o is gated on registered full). No combinational path from mem_rvalid_i to mem_req_o.
// - A core req and a grant of the same port in the same cycle cannot occur, by contract.
// - Starvation: bounded by the one-outstanding-per-port contract. Instr waits at most one data transaction.
// - Reset mid-operation clears pending registers and the FIFO. The memory is reset together with the arbiter, so no stale rvalid arrives after reset.
// - err_o clears only on reset.
// STRUCTURE
// - Package miriscv_mem_arb_pkg holds:
//   - typedef enum logic {SRC_INSTR, SRC_DATA} mem_src_e
//   - localparam ARB_ID_W=1
// - Sub-module miriscv_arb_id_fifo: synchronous FIFO of mem_src_e.
//   - Depth MAX_OUTSTANDING; ports push, pop, full, empty, head.
//   - Wrap-around pointers plus one extra bit for full/empty.
// - Top level contains the pending registers, the fixed-priority select, the response demux and the err logic.
// TESTING
// 1. instr_req_i=1, addr=0x80; mem_gnt_i=1 always; rvalid 2 cycles after grant with rdata=0x13 -> mem_req_o with addr 0x80, we=0, be=0xF; instr_rvalid_o=1 with 0x13; data_rvalid_o stays 0.
// 2. instr_req_i and data_req_i in the same cycle (data addr 0x1000, we=1, wdata=0xDEADBEEF) -> data issued first, instr next cycle; responses route data then instr.
// 3. mem_gnt_i=0 for 3 cycles with both pending -> mem_req_o high and data fields stable for 3 cycles; instr issued only after the data grant.
// 4. MAX_OUTSTANDING=2, hold rvalid off -> 2 grants, then mem_req_o=0 while pending. One rvalid plus a grant in the same cycle keeps occupancy at 2.
// 5. mem_rvalid_i with nothing outstanding, and a second instr_req_i while instr is pending -> err_o=1 and sticky; no *_rvalid_o asserted.
// 6. arstn_i low mid-transaction with 1 outstanding and 1 pending -> all outputs 0 immediately (async); after release, a new request completes normally.

Source files
------------

// File: rtl/miriscv_mem_arb_pkg.sv
// Shared types for the miriscv instruction/data memory arbiter.
package miriscv_mem_arb_pkg;

   typedef enum logic {SRC_INSTR, SRC_DATA} mem_src_e;

   localparam int ARB_ID_W = 1;

endpackage

// File: rtl/miriscv_arb_id_fifo.sv
// In-order FIFO of source IDs for shared-port requests awaiting their response.
module miriscv_arb_id_fifo
   import miriscv_mem_arb_pkg::*;
#(
   parameter int DEPTH = 2
)
(
   input  logic     i_clk,
   input  logic     i_arstn,
   input  logic     i_push,
   input  mem_src_e i_id,
   input  logic     i_pop,
   output logic     o_full,
   output logic     o_empty,
   output mem_src_e o_head
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PW = AW + 1;

   logic [PW-1:0]       r_wptr;
   logic [PW-1:0]       r_rptr;
   logic [ARB_ID_W-1:0] r_mem [2**AW];
   logic [PW-1:0]       w_count;
   logic                w_push;
   logic                w_pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign w_count = r_wptr - r_rptr;
   assign o_full  = (w_count == PW'(DEPTH));
   assign o_empty = (r_wptr == r_rptr);
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_head  = mem_src_e'(r_mem[r_rptr[AW-1:0]]);

   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr[AW-1:0]] <= i_id;
   end

endmodule

// File: rtl/miriscv_mem_arbiter.sv
// Merges the miriscv instruction and data ports onto one shared memory port,
// data first, and routes in-order responses back to the issuing port.
module miriscv_mem_arbiter
   import miriscv_mem_arb_pkg::*;
#(
   parameter int XLEN            = 32,
   parameter int MAX_OUTSTANDING = 2
)
(
   input  logic              clk_i,
   input  logic              arstn_i,
   input  logic              instr_req_i,
   input  logic [XLEN-1:0]   instr_addr_i,
   output logic              instr_rvalid_o,
   output logic [XLEN-1:0]   instr_rdata_o,
   input  logic              data_req_i,
   input  logic              data_we_i,
   input  logic [XLEN/8-1:0] data_be_i,
   input  logic [XLEN-1:0]   data_addr_i,
   input  logic [XLEN-1:0]   data_wdata_i,
   output logic              data_rvalid_o,
   output logic [XLEN-1:0]   data_rdata_o,
   output logic              mem_req_o,
   input  logic              mem_gnt_i,
   output logic              mem_we_o,
   output logic [XLEN/8-1:0] mem_be_o,
   output logic [XLEN-1:0]   mem_addr_o,
   output logic [XLEN-1:0]   mem_wdata_o,
   input  logic              mem_rvalid_i,
   input  logic [XLEN-1:0]   mem_rdata_i,
   output logic              err_o
);

   logic              r_instr_vld;
   logic [XLEN-1:0]   r_instr_addr;
   logic              r_data_vld;
   logic              r_data_we;
   logic [XLEN/8-1:0] r_data_be;
   logic [XLEN-1:0]   r_data_addr;
   logic [XLEN-1:0]   r_data_wdata;
   logic              r_lock_vld;
   mem_src_e          r_lock_src;
   logic              r_err;

   mem_src_e          w_sel;
   mem_src_e          w_head;
   logic              w_full;
   logic              w_empty;
   logic              w_req;
   logic              w_gnt;
   logic              w_rsp;

   // A presented but ungranted request stays selected even if data arrives later.
   always_comb begin
      w_sel = SRC_INSTR;
      if (r_lock_vld)      w_sel = r_lock_src;
      else if (r_data_vld) w_sel = SRC_DATA;
   end

   assign w_req     = (r_instr_vld | r_data_vld) & ~w_full;
   assign w_gnt     = w_req & mem_gnt_i;
   assign w_rsp     = mem_rvalid_i & ~w_empty;
   assign mem_req_o = w_req;

   always_comb begin
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (w_req) begin
         if (w_sel == SRC_DATA) begin
            mem_we_o    = r_data_we;
            mem_be_o    = r_data_be;
            mem_addr_o  = r_data_addr;
            mem_wdata_o = r_data_wdata;
         end else begin
            mem_be_o    = '1;
            mem_addr_o  = r_instr_addr;
         end
      end
   end

   assign instr_rvalid_o = w_rsp & (w_head == SRC_INSTR);
   assign data_rvalid_o  = w_rsp & (w_head == SRC_DATA);
   assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
   assign data_rdata_o   = data_rvalid_o  ? mem_rdata_i : '0;
   assign err_o          = r_err;

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_instr_vld <= 1'b0;
         r_data_vld  <= 1'b0;
         r_lock_vld  <= 1'b0;
         r_lock_src  <= SRC_INSTR;
         r_err       <= 1'b0;
      end else begin
         r_lock_vld <= w_req & ~mem_gnt_i;
         r_lock_src <= w_sel;
         if (w_gnt && (w_sel == SRC_INSTR)) r_instr_vld <= 1'b0;
         if (w_gnt && (w_sel == SRC_DATA))  r_data_vld  <= 1'b0;
         if (instr_req_i && !r_instr_vld)   r_instr_vld <= 1'b1;
         if (data_req_i && !r_data_vld)     r_data_vld  <= 1'b1;
         if ((instr_req_i && r_instr_vld) || (data_req_i && r_data_vld) ||
             (mem_rvalid_i && w_empty))
            r_err <= 1'b1;
      end
   end

   // Payload registers carry no reset; they are only observed while valid.
   always_ff @(posedge clk_i) begin
      if (instr_req_i && !r_instr_vld) r_instr_addr <= instr_addr_i;
      if (data_req_i && !r_data_vld) begin
         r_data_we    <= data_we_i;
         r_data_be    <= data_be_i;
         r_data_addr  <= data_addr_i;
         r_data_wdata <= data_wdata_i;
      end
   end

   miriscv_arb_id_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .i_clk   (clk_i),
      .i_arstn (arstn_i),
      .i_push  (w_gnt),
      .i_id    (w_sel),
      .i_pop   (w_rsp),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Directed bench for miriscv_mem_arbiter with hand-computed expectations.
module tb_miriscv_mem_arbiter;

   localparam int XLEN = 32;

   logic              clk_i = 1'b0;
   logic              arstn_i;
   logic              instr_req_i;
   logic [XLEN-1:0]   instr_addr_i;
   logic              instr_rvalid_o;
   logic [XLEN-1:0]   instr_rdata_o;
   logic              data_req_i;
   logic              data_we_i;
   logic [XLEN/8-1:0] data_be_i;
   logic [XLEN-1:0]   data_addr_i;
   logic [XLEN-1:0]   data_wdata_i;
   logic              data_rvalid_o;
   logic [XLEN-1:0]   data_rdata_o;
   logic              mem_req_o;
   logic              mem_gnt_i;
   logic              mem_we_o;
   logic [XLEN/8-1:0] mem_be_o;
   logic [XLEN-1:0]   mem_addr_o;
   logic [XLEN-1:0]   mem_wdata_o;
   logic              mem_rvalid_i;
   logic [XLEN-1:0]   mem_rdata_i;
   logic              err_o;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   miriscv_mem_arbiter #(
      .XLEN            (XLEN),
      .MAX_OUTSTANDING (2)
   ) dut (
      .clk_i          (clk_i),
      .arstn_i        (arstn_i),
      .instr_req_i    (instr_req_i),
      .instr_addr_i   (instr_addr_i),
      .instr_rvalid_o (instr_rvalid_o),
      .instr_rdata_o  (instr_rdata_o),
      .data_req_i     (data_req_i),
      .data_we_i      (data_we_i),
      .data_be_i      (data_be_i),
      .data_addr_i    (data_addr_i),
      .data_wdata_i   (data_wdata_i),
      .data_rvalid_o  (data_rvalid_o),
      .data_rdata_o   (data_rdata_o),
      .mem_req_o      (mem_req_o),
      .mem_gnt_i      (mem_gnt_i),
      .mem_we_o       (mem_we_o),
      .mem_be_o       (mem_be_o),
      .mem_addr_o     (mem_addr_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_rvalid_i   (mem_rvalid_i),
      .mem_rdata_i    (mem_rdata_i),
      .err_o          (err_o)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic req_instr(input logic [XLEN-1:0] addr);
      instr_req_i  = 1'b1;
      instr_addr_i = addr;
      tick();
      instr_req_i  = 1'b0;
   endtask

   task automatic req_data(input logic [XLEN-1:0] addr, input logic we,
                           input logic [3:0] be, input logic [XLEN-1:0] wdata);
      data_req_i   = 1'b1;
      data_addr_i  = addr;
      data_we_i    = we;
      data_be_i    = be;
      data_wdata_i = wdata;
      tick();
      data_req_i   = 1'b0;
   endtask

   task automatic req_both(input logic [XLEN-1:0] iaddr, input logic [XLEN-1:0] daddr,
                           input logic we, input logic [3:0] be, input logic [XLEN-1:0] wdata);
      instr_req_i  = 1'b1;
      instr_addr_i = iaddr;
      data_req_i   = 1'b1;
      data_addr_i  = daddr;
      data_we_i    = we;
      data_be_i    = be;
      data_wdata_i = wdata;
      tick();
      instr_req_i  = 1'b0;
      data_req_i   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      arstn_i      = 1'b0;
      instr_req_i  = 1'b0;
      instr_addr_i = '0;
      data_req_i   = 1'b0;
      data_we_i    = 1'b0;
      data_be_i    = '0;
      data_addr_i  = '0;
      data_wdata_i = '0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;

      // reset state
      #2;
      chk("rst_req",    32'(mem_req_o), 0);
      chk("rst_be",     32'(mem_be_o), 0);
      chk("rst_err",    32'(err_o), 0);
      chk("rst_irv",    32'(instr_rvalid_o), 0);
      chk("rst_drv",    32'(data_rvalid_o), 0);
      tick();
      tick();
      arstn_i = 1'b1;

      // 1: single instruction fetch
      mem_gnt_i = 1'b1;
      req_instr(32'h80);
      #1;
      chk("t1_req",   32'(mem_req_o), 1);
      chk("t1_addr",  mem_addr_o, 32'h80);
      chk("t1_we",    32'(mem_we_o), 0);
      chk("t1_be",    32'(mem_be_o), 32'hF);
      chk("t1_wdata", mem_wdata_o, 0);
      tick();
      #1;
      chk("t1_idle",  32'(mem_req_o), 0);
      tick();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h13;
      #1;
      chk("t1_irv",   32'(instr_rvalid_o), 1);
      chk("t1_irdat", instr_rdata_o, 32'h13);
      chk("t1_drv",   32'(data_rvalid_o), 0);
      tick();
      mem_rvalid_i = 1'b0;

      // 2: simultaneous requests, data first
      req_both(32'h200, 32'h1000, 1'b1, 4'hF, 32'hDEADBEEF);
      #1;
      chk("t2_daddr", mem_addr_o, 32'h1000);
      chk("t2_dwe",   32'(mem_we_o), 1);
      chk("t2_dwd",   mem_wdata_o, 32'hDEADBEEF);
      tick();
      #1;
      chk("t2_iaddr", mem_addr_o, 32'h200);
      chk("t2_iwe",   32'(mem_we_o), 0);
      tick();
      #1;
      chk("t2_full",  32'(mem_req_o), 0);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h11;
      #1;
      chk("t2_drv",   32'(data_rvalid_o), 1);
      chk("t2_ddat",  data_rdata_o, 32'h11);
      chk("t2_irv0",  32'(instr_rvalid_o), 0);
      tick();
      mem_rdata_i  = 32'h22;
      #1;
      chk("t2_irv",   32'(instr_rvalid_o), 1);
      chk("t2_idat",  instr_rdata_o, 32'h22);
      chk("t2_drv0",  32'(data_rvalid_o), 0);
      tick();
      mem_rvalid_i = 1'b0;

      // 3: grant withheld with both pending
      mem_gnt_i = 1'b0;
      req_both(32'h300, 32'h1004, 1'b0, 4'h1, 32'h0);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t3_hold_req",  32'(mem_req_o), 1);
         chk("t3_hold_addr", mem_addr_o, 32'h1004);
         chk("t3_hold_be",   32'(mem_be_o), 32'h1);
         tick();
      end
      mem_gnt_i = 1'b1;
      #1;
      chk("t3_daddr", mem_addr_o, 32'h1004);
      tick();
      #1;
      chk("t3_iaddr", mem_addr_o, 32'h300);
      tick();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h31;
      #1;
      chk("t3_drv",   32'(data_rvalid_o), 1);
      tick();
      mem_rdata_i  = 32'h32;
      #1;
      chk("t3_irv",   32'(instr_rvalid_o), 1);
      tick();
      mem_rvalid_i = 1'b0;

      // 3b: presented instr request is not overtaken by later data
      mem_gnt_i = 1'b0;
      req_instr(32'h340);
      #1;
      chk("t3b_iaddr", mem_addr_o, 32'h340);
      req_data(32'h1040, 1'b1, 4'hF, 32'hCAFE);
      #1;
      chk("t3b_lock",  mem_addr_o, 32'h340);
      mem_gnt_i = 1'b1;
      tick();
      #1;
      chk("t3b_daddr", mem_addr_o, 32'h1040);
      tick();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h34;
      #1;
      chk("t3b_irv",   32'(instr_rvalid_o), 1);
      tick();
      mem_rdata_i  = 32'h10;
      #1;
      chk("t3b_drv",   32'(data_rvalid_o), 1);
      tick();
      mem_rvalid_i = 1'b0;

      // 4: outstanding limit
      req_both(32'h400, 32'h500, 1'b0, 4'h3, 32'h0);
      #1;
      chk("t4_daddr", mem_addr_o, 32'h500);
      tick();
      #1;
      chk("t4_iaddr", mem_addr_o, 32'h400);
      tick();
      req_instr(32'h404);
      #1;
      chk("t4_full_gate", 32'(mem_req_o), 0);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h51;
      #1;
      chk("t4_drv",       32'(data_rvalid_o), 1);
      chk("t4_no_comb",   32'(mem_req_o), 0);
      tick();
      mem_rvalid_i = 1'b0;
      #1;
      chk("t4_reissue",   mem_addr_o, 32'h404);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h41;
      #1;
      chk("t4_irv",       32'(instr_rvalid_o), 1);
      chk("t4_irdat",     instr_rdata_o, 32'h41);
      tick();
      mem_rvalid_i = 1'b0;
      req_data(32'h504, 1'b0, 4'hF, 32'h0);
      #1;
      chk("t4_dreq",      mem_addr_o, 32'h504);
      tick();
      req_instr(32'h408);
      #1;
      chk("t4_occ_kept2", 32'(mem_req_o), 0);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h42;
      #1;
      chk("t4_irv2",      32'(instr_rvalid_o), 1);
      tick();
      mem_rdata_i  = 32'h52;
      #1;
      chk("t4_drv2",      32'(data_rvalid_o), 1);
      chk("t4_i408",      mem_addr_o, 32'h408);
      tick();
      mem_rdata_i  = 32'h43;
      #1;
      chk("t4_irv3",      32'(instr_rvalid_o), 1);
      chk("t4_irdat3",    instr_rdata_o, 32'h43);
      tick();
      mem_rvalid_i = 1'b0;
      #1;
      chk("t4_drained",   32'(mem_req_o), 0);
      chk("t4_err0",      32'(err_o), 0);

      // 5: protocol errors
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h99;
      #1;
      chk("t5_irv0",  32'(instr_rvalid_o), 0);
      chk("t5_drv0",  32'(data_rvalid_o), 0);
      tick();
      mem_rvalid_i = 1'b0;
      #1;
      chk("t5_err_rv", 32'(err_o), 1);
      tick();
      #1;
      chk("t5_sticky", 32'(err_o), 1);
      arstn_i = 1'b0;
      #1;
      chk("t5_err_clr", 32'(err_o), 0);
      tick();
      arstn_i = 1'b1;
      mem_gnt_i = 1'b0;
      req_instr(32'h600);
      #1;
      chk("t5_err_ok", 32'(err_o), 0);
      req_instr(32'h700);
      #1;
      chk("t5_err_dup", 32'(err_o), 1);
      chk("t5_kept",    mem_addr_o, 32'h600);
      mem_gnt_i = 1'b1;
      tick();
      #1;
      chk("t5_dropped", 32'(mem_req_o), 0);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h66;
      #1;
      chk("t5_irv",     32'(instr_rvalid_o), 1);
      tick();
      mem_rvalid_i = 1'b0;
      #1;
      chk("t5_sticky2", 32'(err_o), 1);

      // 6: asynchronous reset mid-transaction
      arstn_i = 1'b0;
      tick();
      arstn_i = 1'b1;
      req_instr(32'h800);
      tick();
      mem_gnt_i = 1'b0;
      req_data(32'h900, 1'b1, 4'hF, 32'h12345678);
      #1;
      chk("t6_pend",    32'(mem_req_o), 1);
      arstn_i = 1'b0;
      #1;
      chk("t6_req0",    32'(mem_req_o), 0);
      chk("t6_addr0",   mem_addr_o, 0);
      chk("t6_we0",     32'(mem_we_o), 0);
      chk("t6_be0",     32'(mem_be_o), 0);
      chk("t6_wd0",     mem_wdata_o, 0);
      chk("t6_err0",    32'(err_o), 0);
      tick();
      tick();
      arstn_i = 1'b1;
      mem_gnt_i = 1'b1;
      req_instr(32'hA00);
      #1;
      chk("t6_new_req", 32'(mem_req_o), 1);
      chk("t6_new_addr", mem_addr_o, 32'hA00);
      tick();
      #1;
      chk("t6_no_stale", 32'(mem_req_o), 0);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h77;
      #1;
      chk("t6_irv",     32'(instr_rvalid_o), 1);
      chk("t6_irdat",   instr_rdata_o, 32'h77);
      chk("t6_drv0",    32'(data_rvalid_o), 0);
      tick();
      mem_rvalid_i = 1'b0;
      #1;
      chk("t6_err_end", 32'(err_o), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
